// File: rtl/apb_regfile_pkg.sv
// Shared types and constants for the APB wait-state register file.
package apb_regfile_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  localparam int unsigned IDX_ID   = 0;
  localparam int unsigned IDX_WAIT = 1;
  localparam int unsigned WAIT_W   = 4;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_MISALIGN,
    ERR_RANGE,
    ERR_RO_WRITE
  } err_reason_e;

  // The range check precedes the read-only check, so addr[31:2]==0 here means word 0.
  function automatic err_reason_e decode_err(input logic [31:0] addr, input logic wr,
                                             input int unsigned num_regs);
    if (addr[1:0] != 2'b00) return ERR_MISALIGN;
    if (addr >= 32'(num_regs * 4)) return ERR_RANGE;
    if (wr && (addr[31:2] == 30'(IDX_ID))) return ERR_RO_WRITE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state counter: loads the WAIT count at setup and raises a registered ready when it expires.
module apb_wait_counter
  import apb_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              run,
  input  logic              clr,
  input  logic [WAIT_W-1:0] wait_val,
  output logic              ready,
  output logic              ready_nxt
);

  localparam logic [WAIT_W-1:0] ONE = WAIT_W'(1);

  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;

  always_comb begin
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (clr) begin
      cnt_d   = '0;
      ready_d = 1'b0;
    end else if (load) begin
      cnt_d   = wait_val;
      ready_d = (wait_val == '0);
    end else if (run) begin
      cnt_d   = cnt_q - ONE;
      ready_d = (cnt_q == ONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready     = ready_q;
  assign ready_nxt = ready_d;

endmodule

// File: rtl/apb_wait_regfile.sv
// APB4 completer with an ID word, a programmable wait-state register and a byte-strobed register file.
module apb_wait_regfile
  import apb_regfile_pkg::*;
#(
  parameter int unsigned       NUM_REGS     = 16,
  parameter logic [31:0]       ID_VALUE     = 32'hA5B0_0001,
  parameter logic [WAIT_W-1:0] DEFAULT_WAIT = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslerr
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       regs_q [NUM_REGS];
  logic [31:0]       regs_d [NUM_REGS];
  logic [31:0]       prdata_q, prdata_d;
  logic              pslerr_q, pslerr_d;

  err_reason_e      setup_err;
  logic             setup, run, complete, abort, ready_nxt;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_write, cur_err;
  logic [31:0]      rd_word;

  assign setup_err = decode_err(paddr, pwrite, NUM_REGS);
  assign setup     = (state_q == IDLE) && psel && !penable;
  assign run       = (state_q == ACCESS) && psel && !pready;
  assign complete  = (state_q == ACCESS) && psel && penable && pready;
  assign abort     = (state_q == ACCESS) && !psel;

  apb_wait_counter u_wait_counter (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (setup),
    .run       (run),
    .clr       (complete || abort),
    .wait_val  (wait_q),
    .ready     (pready),
    .ready_nxt (ready_nxt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    write_d = write_q;
    err_d   = err_q;
    if (setup) begin
      state_d = ACCESS;
      idx_d   = paddr[IDX_W+1:2];
      write_d = pwrite;
      err_d   = (setup_err != ERR_NONE);
    end else if (complete || abort) begin
      state_d = IDLE;
    end
  end

  // Response data is registered with pready, so with WAIT=0 it must come from the setup-cycle decode.
  always_comb begin
    cur_idx   = setup ? paddr[IDX_W+1:2] : idx_q;
    cur_write = setup ? pwrite : write_q;
    cur_err   = setup ? (setup_err != ERR_NONE) : err_q;
    if (cur_idx == IDX_W'(IDX_ID)) begin
      rd_word = ID_VALUE;
    end else if (cur_idx == IDX_W'(IDX_WAIT)) begin
      rd_word = {{(32 - WAIT_W){1'b0}}, wait_q};
    end else begin
      rd_word = regs_q[cur_idx];
    end
    prdata_d = (ready_nxt && !cur_write && !cur_err) ? rd_word : '0;
    pslerr_d = ready_nxt && cur_err;
  end

  always_comb begin
    wait_d = wait_q;
    regs_d = regs_q;
    if (complete && write_q && !err_q) begin
      if (idx_q == IDX_W'(IDX_WAIT)) begin
        if (pstrb[0]) wait_d = pwdata[WAIT_W-1:0];
      end else begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (pstrb[i]) regs_d[idx_q][8*i +: 8] = pwdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      wait_q   <= DEFAULT_WAIT;
      prdata_q <= '0;
      pslerr_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      err_q    <= err_d;
      wait_q   <= wait_d;
      prdata_q <= prdata_d;
      pslerr_q <= pslerr_d;
      regs_q   <= regs_d;
    end
  end

  assign prdata = prdata_q;
  assign pslerr = pslerr_q;

  a_err_with_ready: assert property (@(posedge clk) disable iff (!reset_n) pslerr |-> pready);

endmodule

// File: tb/tb_apb_wait_regfile.sv
// Scoreboard bench for apb_wait_regfile: the driver queues expected responses, the monitor checks them.
module tb_apb_wait_regfile;

  localparam int unsigned NREG = 16;
  localparam logic [31:0] ID   = 32'hA5B0_0001;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslerr;

  apb_wait_regfile #(
    .NUM_REGS     (NREG),
    .ID_VALUE     (ID),
    .DEFAULT_WAIT (4'd0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .paddr   (paddr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .pready  (pready),
    .prdata  (prdata),
    .pslerr  (pslerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] data;
    int          lat;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_mem [NREG];
  logic [3:0]  m_wait;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          mon_acc = 0;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  task automatic m_reset();
    m_wait = 4'd0;
    for (int i = 0; i < NREG; i++) m_mem[i] = 32'h0;
  endtask

  function automatic logic [31:0] m_read(input int idx);
    if (idx == 0) return ID;
    if (idx == 1) return {28'h0, m_wait};
    return m_mem[idx];
  endfunction

  task automatic m_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    if (idx == 1) begin
      if (s[0]) m_wait = d[3:0];
    end else begin
      for (int i = 0; i < 4; i++) if (s[i]) m_mem[idx][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge with the bus idle.
  task automatic xfer(input logic [31:0] a, input bit w, input logic [31:0] d, input logic [3:0] s,
                      input string tag, input int abort_at, output int done_cyc);
    exp_t e;
    bit   err, got;
    int   idx, n;
    idx   = int'(a[5:2]);
    err   = (a[1:0] != 2'b00) || (a >= 32'(NREG * 4)) || (w && (a < 4));
    e.rd  = !w;
    e.err = err;
    e.lat = 1 + int'(m_wait);
    e.data = (err || w) ? 32'h0 : m_read(idx);
    e.tag = tag;
    if (abort_at < 0) begin
      exp_q.push_back(e);
      if (w && !err) m_write(idx, d, s);
    end
    paddr = a; pwrite = w; pwdata = d; pstrb = s; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    n = 0; got = 0; done_cyc = -1;
    while (!got) begin
      @(negedge clk);
      n++;
      if (pready) begin
        got = 1;
        done_cyc = cyc;
      end else if (abort_at >= 0 && n >= abort_at) begin
        break;
      end else if (n > 40) begin
        chk({tag, "_timeout"}, 32'(n), 32'(e.lat));
        break;
      end
    end
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    if (abort_at >= 0) begin
      repeat (3) begin
        @(negedge clk);
        chk({tag, "_abort_pready"}, {31'h0, pready}, 32'h0);
      end
      @(posedge clk); #1;
    end
  endtask

  // Monitor: counts access cycles since setup and pops one expectation per pready.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_acc = 0;
      end else begin
        if (psel && !penable) begin
          mon_acc = 0;
        end else if (psel && penable) begin
          mon_acc++;
          if (!pready) begin
            chk("hold_prdata", prdata, 32'h0);
            chk("hold_pslerr", {31'h0, pslerr}, 32'h0);
          end
        end
        if (pready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pready: got pready=1 with no pending transfer at %0t", $time);
          end else begin
            mon_e = exp_q.pop_front();
            chk({mon_e.tag, "_lat"}, 32'(mon_acc), 32'(mon_e.lat));
            chk({mon_e.tag, "_pslerr"}, {31'h0, pslerr}, {31'h0, mon_e.err});
            if (mon_e.rd || mon_e.err) chk({mon_e.tag, "_prdata"}, prdata, mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    int c1, c2, dc;
    logic [31:0] a;
    reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready", {31'h0, pready}, 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pslerr", {31'h0, pslerr}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    xfer(32'h0, 0, 32'h0, 4'h0, "rd_id", -1, dc);
    xfer(32'h8, 1, 32'h1122_3344, 4'b0101, "wr8", -1, dc);
    xfer(32'h8, 0, 32'h0, 4'h0, "rd8", -1, dc);
    xfer(32'h4, 1, 32'hFFFF_FFF3, 4'hF, "wr_wait3", -1, dc);
    xfer(32'h4, 0, 32'h0, 4'h0, "rd_wait3", -1, dc);

    xfer(32'h0, 1, 32'hDEAD_0000, 4'hF, "err_wr_id", -1, dc);
    xfer(32'h41, 0, 32'h0, 4'h0, "err_misalign", -1, dc);
    xfer(32'h40, 0, 32'h0, 4'h0, "err_range", -1, dc);
    xfer(32'h8, 1, 32'hFFFF_FFFF, 4'h0, "wr8_nostrb", -1, dc);
    xfer(32'h0, 0, 32'h0, 4'h0, "rd_id2", -1, dc);
    xfer(32'h8, 0, 32'h0, 4'h0, "rd8_again", -1, dc);

    xfer(32'h4, 1, 32'h0000_0005, 4'h1, "wr_wait5", -1, dc);
    xfer(32'hC, 1, 32'hCAFE_F00D, 4'hF, "abort_wr", 1, dc);
    xfer(32'hC, 0, 32'h0, 4'h0, "rd_c_after_abort", -1, dc);

    paddr = 32'h14; pwrite = 1'b1; pwdata = 32'h55AA_55AA; pstrb = 4'hF;
    psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_pready", {31'h0, pready}, 32'h0);
    chk("midrst_prdata", prdata, 32'h0);
    chk("midrst_pslerr", {31'h0, pslerr}, 32'h0);
    psel = 1'b0; penable = 1'b0;
    m_reset();
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    xfer(32'h4, 0, 32'h0, 4'h0, "rd_wait_after_rst", -1, dc);
    xfer(32'h14, 0, 32'h0, 4'h0, "rd14_after_rst", -1, dc);
    xfer(32'h8, 0, 32'h0, 4'h0, "rd8_after_rst", -1, dc);

    xfer(32'h10, 1, 32'hDEAD_BEEF, 4'hF, "b2b_wr", -1, c1);
    xfer(32'h10, 0, 32'h0, 4'h0, "b2b_rd", -1, c2);
    chk("b2b_gap", 32'(c2 - c1), 32'd2);

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: a = 32'($urandom_range(0, 15)) << 2;
        7:                   a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        8:                   a = 32'($urandom_range(64, 255));
        default:             a = $urandom | 32'h100;
      endcase
      xfer(a, 1'($urandom), $urandom, 4'($urandom), "rand", -1, dc);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    for (int i = 0; i < NREG; i++) xfer(32'(i) << 2, 0, 32'h0, 4'h0, "final_rd", -1, dc);

    repeat (2) @(posedge clk);
    chk("pending_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_wait_regfile.md
Name: apb_wait_regfile

Overview:
APB4 completer (slave) that sits directly downstream of the WB-to-APB bridge and answers its paddr/psel/penable/pwrite/pwdata/pstrb requests with pready/prdata/pslerr.
- Holds a small byte-strobed register file, a read-only ID word, and a runtime-programmable wait-state count.
- Lets the bridge's wait handling, error propagation and strobe mapping be exercised against real RTL rather than a bench model.

Parameters:
NUM_REGS  16  number of 32-bit words; power of two, >= 4
ID_VALUE  32'hA5B0_0001  read-only contents of word 0
DEFAULT_WAIT  0  reset value of WAIT register, range 0..15

Ports:
clk  input  1  clock; all state on posedge
reset_n  input  1  asynchronous active-low reset
paddr  input  32  byte address
psel  input  1  completer select
penable  input  1  access phase
pwrite  input  1  1 = write, 0 = read
pwdata  input  32  write data
pstrb  input  4  write byte lanes
pready  output  1  transfer complete, registered
prdata  output  32  read data, valid only while pready=1
pslerr  output  1  error response, valid only while pready=1

Behaviour:
- Reset (async assert, sync release): pready=0, prdata=0, pslerr=0, FSM=IDLE, wait counter=0, WAIT=DEFAULT_WAIT, words 2..NUM_REGS-1 = 0.
- Register map (word index = paddr[log2(NUM_REGS)+1:2]):
  - word 0 = ID, RO;
  - word 1 = WAIT, RW, bits[3:0] only, bits[31:4] read 0;
  - words 2..NUM_REGS-1 = RW general.
- Decode error, computed at setup: paddr[1:0]!=0, or paddr >= NUM_REGS*4, or write to word 0. An errored transfer completes normally with pslerr=1, leaves the register file unchanged, and returns prdata=0.
- FSM IDLE -> ACCESS -> IDLE:
  - IDLE: setup detected (psel=1, penable=0). Latch index, pwrite, error flag and cnt=WAIT. Set pready_q <= (WAIT==0). Go to ACCESS.
  - ACCESS with pready=0 and psel=1: cnt decrements each cycle; pready_q <= (cnt==1).
  - ACCESS with pready=1 and psel=1 and penable=1 (completion edge): commit the write, where lane i updates iff pstrb[i]. pstrb=0 means no change and no error. Then clear pready and go to IDLE.
  - ACCESS with psel=0 (abort): go to IDLE, pready=0, no write.
- Latency: pready rises in access cycle 1+N for N = WAIT sampled at setup, so a transfer takes 2+N cycles in total.
- Back-to-back transfers: a new setup cycle may immediately follow the completion cycle.
- Read path: prdata and pslerr are registered alongside pready, are valid only while pready=1, and are 0 otherwise. pstrb is ignored on reads.
- A write to WAIT takes effect from the next transfer; the current transfer keeps its latched count.
- Reset mid-transfer aborts it: no commit, outputs 0.
- A setup cycle seen while in ACCESS (protocol violation) is ignored until the FSM returns to IDLE.

Decomposition:
- Package apb_regfile_pkg:
  - state enum {IDLE, ACCESS};
  - word-index constants IDX_ID=0, IDX_WAIT=1;
  - WAIT_W=4;
  - decode-error reason enum (for assertions/coverage).
- One sub-module, apb_wait_counter: loads on setup, decrements in ACCESS, produces the registered ready. The register array and decode stay in the top module.

Test Plan:
- Reset then read addr 0x0 with WAIT=0 -> pready high in access cycle 1, prdata=32'hA5B0_0001, pslerr=0.
- Write 0x8 data 32'h1122_3344 pstrb=4'b0101, then read 0x8 -> prdata=32'h0022_0044 (after reset the register held 0).
- Write WAIT=3, then read 0x4 -> pready low for 3 access cycles, high in the 4th; prdata=32'h0000_0003.
- Error responses, each with the register file unchanged:
  - write 0x0: pslerr=1;
  - read 0x41 (misaligned): pslerr=1, prdata=0;
  - read NUM_REGS*4=0x40: pslerr=1.
- WAIT=5, then write 0xC: drop psel in access cycle 2 (abort) -> pready never asserts; readback of 0xC = 0. Assert reset_n low mid-wait on a second write -> outputs 0 immediately, WAIT returns to 0.
- Back-to-back write 0x10 / read 0x10 with WAIT=0 and no idle cycle -> second transfer completes 2 cycles after the first and returns the written data.
